// File: rtl/bus_dev_fifo.sv
// Per-terminal bus FIFO adapter: TX FIFO (host -> bus pending/pop) and RX FIFO (bus push -> host).
// Optional destination filtering on RX is enabled by defining BUS_DEV_FIFO_ADDR_FILTER_EN.

module bus_dev_fifo_core #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_req,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_req,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic         ovf_q, ovf_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic         do_wr, do_rd;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count   = wptr_q - rptr_q;
  assign ovf     = ovf_q;
  // Head is forced to zero when empty so stale entries never leak after reset.
  assign rd_data = empty ? '0 : mem_q[rptr_q[AW-1:0]];

  always_comb begin
    do_rd  = rd_req && !empty;
    // A read in the same cycle frees the slot, so a write into a full FIFO still lands.
    do_wr  = wr_req && (!full || do_rd);
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q | (wr_req && full && !do_rd);
    if (do_wr) begin
      mem_d[wptr_q[AW-1:0]] = wr_data;
      wptr_d                = wptr_q + 1'b1;
    end
    if (do_rd) begin
      rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

module bus_dev_fifo #(
  parameter int         pckg_sz = 16,
  parameter int         depth   = 8,
  parameter logic [7:0] drv_id  = 8'd0,
  parameter logic [7:0] bdcst   = 8'hFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [pckg_sz-1:0]       wr_data,
  output logic                     tx_full,
  output logic                     pndng,
  output logic [pckg_sz-1:0]       D_pop,
  input  logic                     pop,
  input  logic                     push,
  input  logic [pckg_sz-1:0]       D_push,
  input  logic                     rd_en,
  output logic [pckg_sz-1:0]       rd_data,
  output logic                     rx_empty,
  output logic [$clog2(depth):0]   tx_count,
  output logic [$clog2(depth):0]   rx_count,
  output logic                     tx_ovf,
  output logic                     rx_ovf
);
  // Bus handshake: pndng means D_pop holds a valid head; a pop sampled with
  // pndng=1 consumes it at that edge, pop with pndng=0 is ignored.
  logic tx_empty;
  logic addr_match;
  logic addr_hit;

  assign addr_match = (D_push[pckg_sz-1 -: 8] == drv_id) || (D_push[pckg_sz-1 -: 8] == bdcst);

`ifdef BUS_DEV_FIFO_ADDR_FILTER_EN
  assign addr_hit = addr_match;
`else
  // Unfiltered: every delivered packet is taken; routing is the arbiter's job.
  assign addr_hit = addr_match | 1'b1;
`endif

  assign pndng = !tx_empty;

  bus_dev_fifo_core #(.W(pckg_sz), .DEPTH(depth)) u_tx (
    .clk     (clk),
    .reset   (reset),
    .wr_req  (wr_en),
    .wr_data (wr_data),
    .rd_req  (pop),
    .rd_data (D_pop),
    .full    (tx_full),
    .empty   (tx_empty),
    .count   (tx_count),
    .ovf     (tx_ovf)
  );

  logic rx_full_unused;

  bus_dev_fifo_core #(.W(pckg_sz), .DEPTH(depth)) u_rx (
    .clk     (clk),
    .reset   (reset),
    .wr_req  (push && addr_hit),
    .wr_data (D_push),
    .rd_req  (rd_en),
    .rd_data (rd_data),
    .full    (rx_full_unused),
    .empty   (rx_empty),
    .count   (rx_count),
    .ovf     (rx_ovf)
  );
endmodule

// File: tb/tb_bus_dev_fifo.sv
// Directed bench for bus_dev_fifo: queue scoreboard for TX/RX data, direct flag checks.
// Expected RX contents follow BUS_DEV_FIFO_ADDR_FILTER_EN when it is defined.

module tb_bus_dev_fifo;
  localparam int W = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [W-1:0]  wr_data = '0;
  logic          tx_full, pndng;
  logic [W-1:0]  D_pop;
  logic          pop = 1'b0;
  logic          push = 1'b0;
  logic [W-1:0]  D_push = '0;
  logic          rd_en = 1'b0;
  logic [W-1:0]  rd_data;
  logic          rx_empty;
  logic [CW-1:0] tx_count, rx_count;
  logic          tx_ovf, rx_ovf;

  logic [W-1:0] tx_exp_q[$];
  logic [W-1:0] rx_exp_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;

  bus_dev_fifo #(.pckg_sz(16), .depth(8), .drv_id(8'd2), .bdcst(8'hFF)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full),
    .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push), .D_push(D_push),
    .rd_en(rd_en), .rd_data(rd_data), .rx_empty(rx_empty), .tx_count(tx_count),
    .rx_count(rx_count), .tx_ovf(tx_ovf), .rx_ovf(rx_ovf)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: act=%0h req=%0h", name, act, exp);
  endtask

  // monitor: compare consumed heads against the expected queues
  always @(negedge clk) begin
    if (reset) begin
      if (pop && pndng) begin
        if (tx_exp_q.size() == 0) check("tx_unexpected", {16'h0, D_pop}, 32'hFFFF_FFFF);
        else check("tx_data", {16'h0, D_pop}, {16'h0, tx_exp_q.pop_front()});
      end
      if (rd_en && !rx_empty) begin
        if (rx_exp_q.size() == 0) check("rx_unexpected", {16'h0, rd_data}, 32'hFFFF_FFFF);
        else check("rx_data", {16'h0, rd_data}, {16'h0, rx_exp_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    wr_en = 1'b0; pop = 1'b0; push = 1'b0; rd_en = 1'b0;
  endtask

  task automatic do_write(input logic [W-1:0] d, input bit exp_accept);
    wr_en = 1'b1; wr_data = d;
    if (exp_accept) tx_exp_q.push_back(d);
    step();
  endtask

  task automatic do_pop();
    pop = 1'b1;
    step();
  endtask

  task automatic do_push(input logic [W-1:0] d, input bit exp_accept);
    push = 1'b1; D_push = d;
    if (exp_accept) rx_exp_q.push_back(d);
    step();
  endtask

  task automatic do_read();
    rd_en = 1'b1;
    step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
    tx_exp_q.delete();
    rx_exp_q.delete();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_pndng"},    {31'h0, pndng},    32'h0);
    check({tag, "_tx_full"},  {31'h0, tx_full},  32'h0);
    check({tag, "_rx_empty"}, {31'h0, rx_empty}, 32'h1);
    check({tag, "_tx_count"}, {28'h0, tx_count}, 32'h0);
    check({tag, "_rx_count"}, {28'h0, rx_count}, 32'h0);
    check({tag, "_tx_ovf"},   {31'h0, tx_ovf},   32'h0);
    check({tag, "_rx_ovf"},   {31'h0, rx_ovf},   32'h0);
  endtask

  bit filt;

  initial begin
`ifdef BUS_DEV_FIFO_ADDR_FILTER_EN
    filt = 1'b1;
`else
    filt = 1'b0;
`endif
    // reset state
    step();
    do_reset();
    check_idle("reset");
    check("reset_d_pop",   {16'h0, D_pop},   32'h0);
    check("reset_rd_data", {16'h0, rd_data}, 32'h0);

    // three writes, three back-to-back pops
    do_write(16'h0155, 1);
    check("w1_pndng", {31'h0, pndng}, 32'h1);
    check("w1_d_pop", {16'h0, D_pop}, 32'h0155);
    do_write(16'h02AA, 1);
    do_write(16'h0333, 1);
    check("w3_tx_count", {28'h0, tx_count}, 32'd3);
    for (int i = 0; i < 3; i++) do_pop();
    check("pop3_pndng", {31'h0, pndng}, 32'h0);

    // fill, overflow, write+pop while full
    for (int i = 0; i < 8; i++) do_write(16'h1000 + 16'(i), 1);
    check("fill_tx_full",  {31'h0, tx_full},  32'h1);
    check("fill_tx_count", {28'h0, tx_count}, 32'd8);
    check("fill_tx_ovf",   {31'h0, tx_ovf},   32'h0);
    do_write(16'hDEAD, 0);
    check("ovf_tx_ovf",   {31'h0, tx_ovf},   32'h1);
    check("ovf_tx_count", {28'h0, tx_count}, 32'd8);
    wr_en = 1'b1; wr_data = 16'h2222; pop = 1'b1;
    tx_exp_q.push_back(16'h2222);
    step();
    check("wp_tx_count", {28'h0, tx_count}, 32'd8);
    check("wp_tx_ovf",   {31'h0, tx_ovf},   32'h1);
    for (int i = 0; i < 7; i++) do_pop();
    check("wp_new_head", {16'h0, D_pop}, 32'h2222);
    do_pop();
    check("drain_pndng", {31'h0, pndng}, 32'h0);

    // interleaved write/pop across pointer wrap
    do_reset();
    for (int i = 0; i < 20; i++) begin
      do_write(16'h3000 + 16'(i), 1);
      do_pop();
    end
    check("wrap_tx_count", {28'h0, tx_count}, 32'd0);
    check("wrap_tx_ovf",   {31'h0, tx_ovf},   32'h0);

    // RX address handling (drv_id = 2)
    do_push(16'h02AB, 1);
    check("rx1_rx_empty", {31'h0, rx_empty}, 32'h0);
    check("rx1_rd_data",  {16'h0, rd_data},  32'h02AB);
    do_push(16'h03CD, !filt);
    do_push(16'hFF11, 1);
    check("rx_filter_count", {28'h0, rx_count}, filt ? 32'd2 : 32'd3);
    check("rx_filter_ovf",   {31'h0, rx_ovf},   32'h0);
    for (int i = 0; i < (filt ? 2 : 3); i++) do_read();
    check("rx_drain_empty", {31'h0, rx_empty}, 32'h1);

    // RX full, overflow, push+read while full
    for (int i = 0; i < 8; i++) do_push(16'h0200 + 16'(i), 1);
    check("rxfill_count", {28'h0, rx_count}, 32'd8);
    do_push(16'h02EE, 0);
    check("rxovf_flag",  {31'h0, rx_ovf},   32'h1);
    check("rxovf_count", {28'h0, rx_count}, 32'd8);
    push = 1'b1; D_push = 16'h02F0; rd_en = 1'b1;
    rx_exp_q.push_back(16'h02F0);
    step();
    check("rxpr_count", {28'h0, rx_count}, 32'd8);
    for (int i = 0; i < 8; i++) do_read();
    check("rxpr_empty", {31'h0, rx_empty}, 32'h1);

    // mid-transfer reset with pop/rd_en asserted during reset
    do_reset();
    for (int i = 0; i < 5; i++) do_write(16'h4000 + 16'(i), 1);
    for (int i = 0; i < 3; i++) do_push(16'h0250 + 16'(i), 1);
    check("pre_rst_tx_count", {28'h0, tx_count}, 32'd5);
    check("pre_rst_rx_count", {28'h0, rx_count}, 32'd3);
    reset = 1'b0; pop = 1'b1; rd_en = 1'b1;
    step();
    reset = 1'b1;
    tx_exp_q.delete();
    rx_exp_q.delete();
    check_idle("midrst");

    // pop / rd_en on empty FIFOs
    pop = 1'b1; rd_en = 1'b1;
    step();
    check_idle("empty_ops");
    do_write(16'h5A5A, 1);
    check("after_empty_d_pop",    {16'h0, D_pop},    32'h5A5A);
    check("after_empty_tx_count", {28'h0, tx_count}, 32'd1);
    do_pop();

    check("tx_queue_left", tx_exp_q.size(), 32'd0);
    check("rx_queue_left", rx_exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/bus_dev_fifo.md
# bus_dev_fifo

Per-terminal FIFO adapter between one device and the shared bus arbiter. TX side buffers host packets and presents them to the bus as a pending/pop interface (`pndng`, `D_pop`, `pop`). RX side captures packets the bus delivers through `push`/`D_push` and queues them for the host. One instance per bus terminal, indexed by `drv_id`; this is the stage that feeds and drains the bus generator/arbiter.

## Interface
- `pckg_sz`, 16: packet width in bits; bits `[pckg_sz-1:pckg_sz-8]` hold the destination ID.
- `depth`, 8: entries per FIFO (TX and RX each); power of two, ≥2.
- `drv_id`, 0: this terminal's 8-bit ID.
- `bdcst`, 8'hFF: broadcast destination ID.

Ports:
- `clk` in 1: single clock, all logic rising-edge.
- `reset` in 1: synchronous, active-low; sampled on `clk`.
- `wr_en` in 1: host write into TX FIFO.
- `wr_data` in pckg_sz: host TX packet.
- `tx_full` out 1: TX FIFO full.
- `pndng` out 1: TX FIFO non-empty (to bus).
- `D_pop` out pckg_sz: TX head packet (to bus), first-word fall-through.
- `pop` in 1: bus consumes TX head.
- `push` in 1: bus delivers a packet.
- `D_push` in pckg_sz: delivered packet.
- `rd_en` in 1: host consumes RX head.
- `rd_data` out pckg_sz: RX head packet, first-word fall-through.
- `rx_empty` out 1: RX FIFO empty.
- `tx_count`, `rx_count` out $clog2(depth)+1: occupancy.
- `tx_ovf`, `rx_ovf` out 1: sticky overflow flags.

## Operation
- Each FIFO: circular buffer, read/write pointers of $clog2(depth)+1 bits (extra wrap bit); full = same index, differing wrap bit; empty = pointers equal.
- TX write: `wr_en` and not full → store `wr_data`, advance wptr. `wr_en` while full and no same-cycle `pop` → packet dropped, `tx_ovf` set.
- TX full plus `wr_en` plus `pop` in the same cycle → both happen; count unchanged.
- TX pop: `pop` while non-empty → advance rptr. `pop` while empty → ignored, no pointer or flag change.
- `pndng` = !tx_empty; `D_pop` = mem[rptr]; `D_pop` is don't-care when empty.
- RX accept: `push` and packet addressed to this terminal (see Configuration) → enqueue. Full RX with no same-cycle `rd_en` → dropped, `rx_ovf` set. Full RX with `rd_en` → accepted.
- `rd_en` while empty → ignored.
- Non-addressed pushes are silently discarded and do not set `rx_ovf`.
- Overflow flags clear only on reset.
- Reset (including mid-transfer): all pointers 0, `pndng`=0, `tx_full`=0, `rx_empty`=1, counts 0, `tx_ovf`=`rx_ovf`=0, `D_pop`/`rd_data`=0. Buffered contents are discarded; all inputs are ignored during the reset cycle.

## Timing
- Write at edge N → `pndng`=1, `D_pop` valid, `tx_count` incremented, all visible after edge N (cycle N+1). TX latency is 1 cycle.
- `pop` sampled at edge N → next entry on `D_pop` after edge N; `pndng` drops after edge N if the FIFO became empty.
- Bus may hold `pop` on consecutive cycles; this sustains one packet per cycle.
- `push` at edge N → `rx_empty`=0 and `rd_data` valid after edge N.
- Outputs are driven from registers/pointers only. `D_pop` and `rd_data` are combinational mux reads of the memory; no input→output combinational path.

## Configuration
- `BUS_DEV_FIFO_ADDR_FILTER_EN` defined: a push is accepted only if `D_push[pckg_sz-1:pckg_sz-8]` equals `drv_id` or `bdcst`.
- Not defined: every push is accepted regardless of ID. Routing correctness is then left to the arbiter.

## Test plan
- Reset, then write 16'h0155, 16'h02AA, 16'h0333 → `pndng`=1 the next cycle, `D_pop`=16'h0155. Three back-to-back pops return the packets in order; `pndng`=0 after the third pop.
- Fill TX with 8 writes → `tx_full`=1, `tx_count`=8.
  - 9th write alone → dropped, `tx_ovf`=1.
  - Then write plus pop in the same cycle → `tx_count` stays 8, new packet appears after 7 more pops.
- Write/pop wrap: 20 interleaved write/pop pairs with incrementing data → data order preserved across pointer wrap; no overflow flags set.
- With `drv_id`=2 and filter enabled, push 16'h02AB, 16'h03CD, 16'hFF11 → RX holds 16'h02AB then 16'hFF11; `rx_count`=2. With the filter disabled → `rx_count`=3.
- Assert `reset`=0 with TX count 5 and RX count 3 → next cycle `pndng`=0, `rx_empty`=1, counts 0, flags 0. `pop`/`rd_en` asserted during reset have no effect.
- `pop` and `rd_en` on empty FIFOs → no pointer change, counts stay 0, no flags set.
